// File: rtl/y86_instr_writer.sv
// Y86-64 instruction encoder: packs one decoded instruction into 1/2/9/10 bytes
// and streams them, one byte per cycle, into instruction memory at a write pointer.
module y86_instr_writer #(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        addr_load,
  input  logic [63:0] addr_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valC,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic [63:0] wr_ptr,
  output logic        done,
  output logic        instr_err,
  output logic        imem_err
);

  localparam int unsigned BUF_BYTES = 10;
  localparam int unsigned IDX_W     = 4;
  localparam logic [63:0] MAX_ADDR  = 64'(MEM_SIZE - 1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                      state, state_n;
  logic [BUF_BYTES-1:0][7:0]   ibuf, ibuf_n;
  logic [IDX_W-1:0]            idx, idx_n;
  logic [IDX_W-1:0]            len, len_n;
  logic [63:0]                 wr_ptr_n;
  logic                        mem_we_n;
  logic [63:0]                 mem_addr_n;
  logic [7:0]                  mem_wdata_n;
  logic                        done_n;
  logic                        instr_err_n;
  logic                        imem_err_n;
  logic [IDX_W-1:0]            accept_len;
  logic [BUF_BYTES-1:0][7:0]   packed_instr;

  // Encoded length per icode; 0 marks an invalid icode.
  function automatic logic [IDX_W-1:0] instr_len(input logic [3:0] ic);
    logic [IDX_W-1:0] n;
    case (ic)
      4'h0, 4'h1, 4'h9:        n = IDX_W'(1);
      4'h2, 4'h6, 4'hA, 4'hB:  n = IDX_W'(2);
      4'h3, 4'h4, 4'h5:        n = IDX_W'(10);
      4'h7, 4'h8:              n = IDX_W'(9);
      default:                 n = IDX_W'(0);
    endcase
    return n;
  endfunction

  // Byte image of the instruction; valC is little-endian after the optional register byte.
  function automatic logic [BUF_BYTES-1:0][7:0] pack_instr(
    input logic [3:0]       ic,
    input logic [3:0]       fn,
    input logic [3:0]       ra,
    input logic [3:0]       rb,
    input logic [63:0]      vc,
    input logic [IDX_W-1:0] n
  );
    logic [BUF_BYTES-1:0][7:0] p;
    p    = '0;
    p[0] = {ic, fn};
    if (n == IDX_W'(9)) begin
      for (int i = 0; i < 8; i++) p[i+1] = vc[8*i +: 8];
    end else begin
      p[1] = {ra, rb};
      if (n == IDX_W'(10)) begin
        for (int i = 0; i < 8; i++) p[i+2] = vc[8*i +: 8];
      end
    end
    return p;
  endfunction

  assign in_ready     = (state == IDLE) && !addr_load && !imem_err;
  assign accept_len   = instr_len(icode);
  assign packed_instr = pack_instr(icode, ifun, rA, rB, valC, accept_len);

  // Next-state logic; write outputs are computed one cycle ahead so they leave registers.
  always_comb begin
    state_n     = state;
    ibuf_n      = ibuf;
    idx_n       = idx;
    len_n       = len;
    wr_ptr_n    = wr_ptr;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    done_n      = 1'b0;
    instr_err_n = 1'b0;
    imem_err_n  = imem_err;

    case (state)
      IDLE: begin
        if (addr_load) begin
          wr_ptr_n = addr_in;
        end else if (in_valid && in_ready) begin
          if (accept_len == IDX_W'(0)) begin
            instr_err_n = 1'b1;
          end else if (wr_ptr > MAX_ADDR) begin
            imem_err_n = 1'b1;
          end else begin
            ibuf_n      = packed_instr;
            len_n       = accept_len;
            idx_n       = IDX_W'(1);
            mem_we_n    = 1'b1;
            mem_addr_n  = wr_ptr;
            mem_wdata_n = packed_instr[0];
            wr_ptr_n    = wr_ptr + 64'd1;
            done_n      = (accept_len == IDX_W'(1));
            state_n     = EMIT;
          end
        end
      end

      EMIT: begin
        // idx counts bytes already presented; idx == len means the last byte is on the bus now.
        if (idx == len) begin
          state_n = IDLE;
        end else if (wr_ptr > MAX_ADDR) begin
          imem_err_n = 1'b1;
          state_n    = IDLE;
        end else begin
          mem_we_n    = 1'b1;
          mem_addr_n  = wr_ptr;
          mem_wdata_n = ibuf[idx];
          wr_ptr_n    = wr_ptr + 64'd1;
          idx_n       = idx + IDX_W'(1);
          done_n      = ((idx + IDX_W'(1)) == len);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ibuf      <= '0;
      idx       <= '0;
      len       <= '0;
      wr_ptr    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      instr_err <= 1'b0;
      imem_err  <= 1'b0;
    end else begin
      state     <= state_n;
      ibuf      <= ibuf_n;
      idx       <= idx_n;
      len       <= len_n;
      wr_ptr    <= wr_ptr_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      done      <= done_n;
      instr_err <= instr_err_n;
      imem_err  <= imem_err_n;
    end
  end

endmodule

// File: tb/tb_y86_instr_writer.sv
// Directed bench for y86_instr_writer: records every byte write into a memory
// image and compares it with hand-encoded instruction bytes.
module tb_y86_instr_writer;

  localparam int unsigned MEM_SIZE = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        addr_load;
  logic [63:0] addr_in;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [63:0] wr_ptr;
  logic        done, instr_err, imem_err;

  logic [7:0]  mem [MEM_SIZE];
  int          wcount, dcount, oob_count;
  logic [63:0] done_addr;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  y86_instr_writer #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .reset(reset), .addr_load(addr_load), .addr_in(addr_in),
    .in_valid(in_valid), .in_ready(in_ready), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .valC(valC), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .wr_ptr(wr_ptr), .done(done),
    .instr_err(instr_err), .imem_err(imem_err)
  );

  // Memory image built from the write strobe as seen at each active edge
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_addr < 64'(MEM_SIZE)) mem[mem_addr[9:0]] = mem_wdata;
      else oob_count++;
      wcount++;
      if (done) done_addr = mem_addr;
    end
    if (done) dcount++;
  end

  task automatic clear_log();
    wcount = 0; dcount = 0; oob_count = 0; done_addr = '1;
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'hEE;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; addr_load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_addr(input logic [63:0] a);
    addr_load = 1'b1; addr_in = a;
    @(negedge clk);
    addr_load = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc, output bit to);
    int t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    to = !in_ready;
    if (!to) begin
      icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_ready(output bit to);
    int t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    to = !in_ready;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (wr_ptr !== 64'd0) $display("FAIL reset_wr_ptr got %h want 0", wr_ptr); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got %b want 0", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 64'd0 || mem_wdata !== 8'd0)
      $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_addr, mem_wdata); else n_pass++;
    n_checks++; if ({done, instr_err, imem_err} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {done, instr_err, imem_err}); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_irmovq();
    logic [7:0] exp [10];
    bit to;
    int k;
    exp = '{8'h30, 8'hF2, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    clear_log();
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF, to);
    k = 1;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    n_checks++; if (to || k != 11) $display("FAIL irmovq_latency got %0d want 11", k); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (mem[i] !== exp[i]) $display("FAIL irmovq_byte%0d got %h want %h", i, mem[i], exp[i]);
      else n_pass++;
    end
    n_checks++; if (wr_ptr !== 64'd10) $display("FAIL irmovq_wr_ptr got %0d want 10", wr_ptr); else n_pass++;
    n_checks++; if (dcount != 1 || done_addr !== 64'd9)
      $display("FAIL irmovq_done got count %0d addr %0d want 1 at 9", dcount, done_addr); else n_pass++;
    n_checks++; if (wcount != 10) $display("FAIL irmovq_wcount got %0d want 10", wcount); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [4];
    bit to0, to1, to2, to3;
    exp = '{8'h00, 8'h10, 8'h60, 8'h23};
    load_addr(64'd0);
    clear_log();
    send(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, to0);
    send(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, to1);
    send(4'h6, 4'h0, 4'h2, 4'h3, 64'd0, to2);
    wait_ready(to3);
    n_checks++; if (to0 || to1 || to2 || to3) $display("FAIL b2b_timeout got 1 want 0"); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem[i] !== exp[i]) $display("FAIL b2b_byte%0d got %h want %h", i, mem[i], exp[i]);
      else n_pass++;
    end
    n_checks++; if (wr_ptr !== 64'd4) $display("FAIL b2b_wr_ptr got %0d want 4", wr_ptr); else n_pass++;
    n_checks++; if (dcount != 3) $display("FAIL b2b_done_count got %0d want 3", dcount); else n_pass++;
  endtask

  task automatic test_jump_load();
    logic [7:0] exp [9];
    bit to0, to1;
    exp = '{8'h73, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load_addr(64'h100);
    clear_log();
    send(4'h7, 4'h3, 4'hF, 4'hF, 64'h200, to0);
    @(negedge clk);
    addr_load = 1'b1; addr_in = 64'h3FF;   // must be ignored while emitting
    @(negedge clk);
    addr_load = 1'b0;
    wait_ready(to1);
    n_checks++; if (to0 || to1) $display("FAIL jxx_timeout got 1 want 0"); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (mem[16'h100 + i] !== exp[i]) $display("FAIL jxx_byte%0d got %h want %h", i, mem[16'h100 + i], exp[i]);
      else n_pass++;
    end
    n_checks++; if (wr_ptr !== 64'h109) $display("FAIL jxx_wr_ptr got %h want 109", wr_ptr); else n_pass++;
    n_checks++; if (wcount != 9) $display("FAIL jxx_wcount got %0d want 9", wcount); else n_pass++;
  endtask

  task automatic test_invalid();
    bit to0, to1;
    clear_log();
    send(4'hC, 4'h0, 4'h1, 4'h2, 64'h55, to0);
    n_checks++; if (to0 || instr_err !== 1'b1) $display("FAIL inv_err_pulse got %b want 1", instr_err); else n_pass++;
    n_checks++; if (mem_we !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL inv_idle got we %b ready %b want 0 1", mem_we, in_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (instr_err !== 1'b0) $display("FAIL inv_err_clear got %b want 0", instr_err); else n_pass++;
    n_checks++; if (wcount != 0 || wr_ptr !== 64'h109)
      $display("FAIL inv_no_write got wcount %0d ptr %h want 0 109", wcount, wr_ptr); else n_pass++;
    send(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, to0);
    wait_ready(to1);
    n_checks++; if (to0 || to1 || mem[10'h109] !== 8'h10 || wr_ptr !== 64'h10A)
      $display("FAIL inv_recover got byte %h ptr %h want 10 10a", mem[10'h109], wr_ptr); else n_pass++;
  endtask

  task automatic test_imem_bound();
    logic [7:0] exp [4];
    bit to;
    int t;
    exp = '{8'h30, 8'hF2, 8'hEF, 8'hCD};
    load_addr(64'd1020);
    clear_log();
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF, to);
    t = 0;
    while (!imem_err && t < 30) begin @(negedge clk); t++; end
    n_checks++; if (to || imem_err !== 1'b1) $display("FAIL imem_err_set got %b want 1", imem_err); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem[1020 + i] !== exp[i]) $display("FAIL imem_byte%0d got %h want %h", i, mem[1020 + i], exp[i]);
      else n_pass++;
    end
    n_checks++; if (wcount != 4 || oob_count != 0 || dcount != 0)
      $display("FAIL imem_writes got w %0d oob %0d done %0d want 4 0 0", wcount, oob_count, dcount); else n_pass++;
    icode = 4'h1; ifun = 4'h0; in_valid = 1'b1;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (imem_err !== 1'b1 || in_ready !== 1'b0 || wcount != 4)
      $display("FAIL imem_sticky got err %b ready %b w %0d want 1 0 4", imem_err, in_ready, wcount); else n_pass++;
  endtask

  task automatic test_reset_mid_emit();
    bit to;
    int t;
    do_reset();
    n_checks++; if (imem_err !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rst_clear got err %b ready %b want 0 1", imem_err, in_ready); else n_pass++;
    clear_log();
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h10, to);
    t = 0;
    while (!(mem_we && mem_addr == 64'd2) && t < 20) begin @(negedge clk); t++; end
    n_checks++; if (to || !(mem_we && mem_addr == 64'd2))
      $display("FAIL rst_third_byte got we %b addr %0d want 1 2", mem_we, mem_addr); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_we !== 1'b0 || wr_ptr !== 64'd0 || in_ready !== 1'b1)
      $display("FAIL rst_abort got we %b ptr %0d ready %b want 0 0 1", mem_we, wr_ptr, in_ready); else n_pass++;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (wcount != 3 || mem[0] !== 8'h40 || mem[1] !== 8'h12 || mem[2] !== 8'h10 || mem[3] !== 8'hEE)
      $display("FAIL rst_partial got w %0d bytes %h %h %h %h want 3 40 12 10 ee",
               wcount, mem[0], mem[1], mem[2], mem[3]); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; addr_load = 1'b0; addr_in = '0; in_valid = 1'b0;
    icode = '0; ifun = '0; rA = '0; rB = '0; valC = '0;
    clear_log();
    @(negedge clk);
    test_reset();
    test_irmovq();
    test_back_to_back();
    test_jump_load();
    test_invalid();
    test_imem_bound();
    test_reset_mid_emit();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
